// File: rtl/s_memory_checker.sv
`default_nettype none
// ============================================================================
// Module   : s_memory_checker
// Purpose  : Sweeps the 256-entry S memory and flags duplicated values
//            (non-permutation). Optional macro S_IDENTITY_CHECK_EN also
//            requires S[i] == i.
// Revision : 1.0 - initial release
// ============================================================================
module s_memory_checker #(
    parameter int READ_LATENCY = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] q,
    output logic [7:0] address,
    output logic       selector,
    output logic       busy,
    output logic       finish,
    output logic       pass,
    output logic [8:0] error_count,
    output logic [7:0] first_bad_addr
);

    localparam logic [1:0] c_drain_last = 2'(READ_LATENCY - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_next_state;
    logic [7:0]        r_counter;
    logic [1:0]        r_drain_cnt;
    logic [255:0]      r_seen;
    logic [READ_LATENCY-1:0] r_vld;
    logic [7:0]        r_tag [READ_LATENCY];
    logic [8:0]        r_err_count;
    logic [7:0]        r_first_bad;
    logic              r_pass;

    logic              w_start_acc;
    logic              w_chk_vld;
    logic [7:0]        w_chk_tag;
    logic              w_dup;
    logic              w_id_err;
    logic              w_err;

    assign w_start_acc = (r_state == S_IDLE) && start;
    assign w_chk_vld   = r_vld[READ_LATENCY-1];
    assign w_chk_tag   = r_tag[READ_LATENCY-1];
    assign w_dup       = r_seen[q];

`ifdef S_IDENTITY_CHECK_EN
    assign w_id_err = (q != w_chk_tag);
`else
    assign w_id_err = 1'b0;
`endif

    // Both checks on one read fold into a single error.
    assign w_err = w_chk_vld && (w_dup || w_id_err);

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next_state = S_ISSUE;
            S_ISSUE: if (r_counter == 8'hFF) w_next_state = S_DRAIN;
            S_DRAIN: if (r_drain_cnt == c_drain_last) w_next_state = S_DONE;
            S_DONE:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_counter   <= 8'h00;
            r_drain_cnt <= 2'd0;
            r_vld       <= '0;
            for (int i = 0; i < READ_LATENCY; i++) begin
                r_tag[i] <= 8'h00;
            end
        end else begin
            if (w_start_acc) begin
                r_counter <= 8'h00;
            end else if (r_state == S_ISSUE) begin
                r_counter <= r_counter + 8'd1;
            end

            if (r_state == S_DRAIN) begin
                r_drain_cnt <= r_drain_cnt + 2'd1;
            end else begin
                r_drain_cnt <= 2'd0;
            end

            // Tag pipeline tracks which address the current q belongs to.
            r_vld[0] <= (r_state == S_ISSUE);
            r_tag[0] <= r_counter;
            for (int i = 1; i < READ_LATENCY; i++) begin
                r_vld[i] <= r_vld[i-1];
                r_tag[i] <= r_tag[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_seen      <= '0;
            r_err_count <= 9'd0;
            r_first_bad <= 8'h00;
            r_pass      <= 1'b0;
        end else if (w_start_acc) begin
            r_seen      <= '0;
            r_err_count <= 9'd0;
            r_first_bad <= 8'h00;
            r_pass      <= 1'b0;
        end else begin
            if (w_chk_vld) begin
                r_seen[q] <= 1'b1;
            end
            if (w_err) begin
                r_err_count <= r_err_count + 9'd1;
                if (r_err_count == 9'd0) begin
                    r_first_bad <= w_chk_tag;
                end
            end
            if (r_state == S_DONE) begin
                r_pass <= (r_err_count == 9'd0);
            end
        end
    end

    assign address        = r_counter;
    assign selector       = (r_state == S_ISSUE) || (r_state == S_DRAIN);
    assign busy           = (r_state != S_IDLE);
    assign finish         = (r_state == S_DONE);
    assign pass           = (r_state == S_DONE) ? (r_err_count == 9'd0) : r_pass;
    assign error_count    = r_err_count;
    assign first_bad_addr = r_first_bad;

endmodule
`default_nettype wire

// File: tb/tb_s_memory_checker.sv
`default_nettype none
// ============================================================================
// Module   : tb_s_memory_checker
// Purpose  : Directed self-checking bench for s_memory_checker, L=1 and L=2.
// Revision : 1.0 - initial release
// ============================================================================
module tb_s_memory_checker;

    logic       clk = 1'b0;
    logic       reset;
    logic       start1, start2;
    logic [7:0] q1, q2;
    logic [7:0] address1, address2;
    logic       selector1, selector2, busy1, busy2, finish1, finish2, pass1, pass2;
    logic [8:0] error_count1, error_count2;
    logic [7:0] first_bad1, first_bad2;

    logic [7:0] mem [256];
    logic [7:0] rd2a;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    s_memory_checker #(.READ_LATENCY(1)) u_dut1 (
        .clk(clk), .reset(reset), .start(start1), .q(q1),
        .address(address1), .selector(selector1), .busy(busy1),
        .finish(finish1), .pass(pass1), .error_count(error_count1),
        .first_bad_addr(first_bad1)
    );

    s_memory_checker #(.READ_LATENCY(2)) u_dut2 (
        .clk(clk), .reset(reset), .start(start2), .q(q2),
        .address(address2), .selector(selector2), .busy(busy2),
        .finish(finish2), .pass(pass2), .error_count(error_count2),
        .first_bad_addr(first_bad2)
    );

    // Synchronous RAM models sharing one content array
    always @(posedge clk) begin
        q1   <= mem[address1];
        rd2a <= mem[address2];
        q2   <= rd2a;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fill_identity();
        for (int i = 0; i < 256; i++) mem[i] = 8'(i);
    endtask

    task automatic drive_start(input bit use2, input bit v);
        if (use2) start2 = v;
        else      start1 = v;
    endtask

    // Start is sampled in cycle 0; cycles 1..max_cyc are observed.
    task automatic sweep(input bit use2, input int hold_until, input int p1, input int p2,
                         input int max_cyc, output int fin1, output int fin2, output int nfin,
                         output int sel_bad, output int addr_bad, output int pass_fin);
        int lat;
        logic sel, fin, ps;
        logic [7:0] adr;
        lat = use2 ? 2 : 1;
        fin1 = -1; fin2 = -1; nfin = 0; sel_bad = 0; addr_bad = 0; pass_fin = -1;
        drive_start(use2, 1'b1);
        for (int cyc = 1; cyc <= max_cyc; cyc++) begin
            tick();
            drive_start(use2, (cyc < hold_until) || (cyc == p1) || (cyc == p2));
            sel = use2 ? selector2 : selector1;
            adr = use2 ? address2  : address1;
            fin = use2 ? finish2   : finish1;
            ps  = use2 ? pass2     : pass1;
            if (cyc <= 257 + lat) begin
                if (sel !== (cyc <= 256 + lat)) sel_bad++;
                if (cyc <= 256 && adr !== 8'(cyc - 1)) addr_bad++;
                if (cyc > 256 && adr !== 8'h00) addr_bad++;
            end
            if (fin) begin
                nfin++;
                if (nfin == 1) begin
                    fin1 = cyc;
                    pass_fin = int'(ps);
                end else if (nfin == 2) begin
                    fin2 = cyc;
                end
            end
        end
        drive_start(use2, 1'b0);
    endtask

    int f1, f2, nf, sb, ab, pf;

    initial begin
        reset = 1'b1; start1 = 1'b0; start2 = 1'b0;
        fill_identity();
        tick(); tick(); tick();
        reset = 1'b0;
        tick();

        // Reset state
        check("rst_address", address1, 8'h00);
        check("rst_selector", selector1, 1'b0);
        check("rst_busy", busy1, 1'b0);
        check("rst_finish", finish1, 1'b0);
        check("rst_pass", pass1, 1'b0);
        check("rst_errcnt", error_count1, 9'd0);
        check("rst_firstbad", first_bad1, 8'h00);
        check("rst_busy_l2", busy2, 1'b0);

        // Identity, L=1
        sweep(1'b0, 1, -1, -1, 260, f1, f2, nf, sb, ab, pf);
        check("id_fin_cycle", f1, 258);
        check("id_fin_count", nf, 1);
        check("id_selector", sb, 0);
        check("id_address", ab, 0);
        check("id_pass_done", pf, 1);
        check("id_pass_held", pass1, 1'b1);
        check("id_errcnt", error_count1, 9'd0);
        check("id_firstbad", first_bad1, 8'h00);
        check("id_busy_after", busy1, 1'b0);

        // Duplicate at address 9
        fill_identity();
        mem[9] = 8'h05;
        sweep(1'b0, 1, -1, -1, 260, f1, f2, nf, sb, ab, pf);
        check("dup_fin_cycle", f1, 258);
        check("dup_pass_done", pf, 0);
        check("dup_errcnt", error_count1, 9'd1);
        check("dup_firstbad", first_bad1, 8'h09);
        check("dup_pass_held", pass1, 1'b0);

        // Swapped pair 3/4
        fill_identity();
        mem[3] = 8'h04;
        mem[4] = 8'h03;
        sweep(1'b0, 1, -1, -1, 260, f1, f2, nf, sb, ab, pf);
`ifdef S_IDENTITY_CHECK_EN
        check("swap_errcnt", error_count1, 9'd2);
        check("swap_firstbad", first_bad1, 8'h03);
        check("swap_pass", pass1, 1'b0);
`else
        check("swap_errcnt", error_count1, 9'd0);
        check("swap_firstbad", first_bad1, 8'h00);
        check("swap_pass", pass1, 1'b1);
`endif

        // Identity, L=2
        fill_identity();
        sweep(1'b1, 1, -1, -1, 261, f1, f2, nf, sb, ab, pf);
        check("l2_fin_cycle", f1, 259);
        check("l2_selector", sb, 0);
        check("l2_address", ab, 0);
        check("l2_pass", pf, 1);
        check("l2_errcnt", error_count2, 9'd0);

        // Duplicate late in the sweep, L=2
        mem[200] = 8'h10;
        sweep(1'b1, 1, -1, -1, 261, f1, f2, nf, sb, ab, pf);
        check("l2dup_errcnt", error_count2, 9'd1);
        check("l2dup_firstbad", first_bad2, 8'hC8);
        check("l2dup_pass", pass2, 1'b0);

        // Reset mid-sweep at cycle 100
        fill_identity();
        mem[9] = 8'h05;
        start1 = 1'b1;
        for (int cyc = 1; cyc <= 100; cyc++) begin
            tick();
            start1 = 1'b0;
        end
        check("mid_errcnt_live", error_count1, 9'd1);
        check("mid_firstbad_live", first_bad1, 8'h09);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mid_selector", selector1, 1'b0);
        check("mid_busy", busy1, 1'b0);
        check("mid_errcnt", error_count1, 9'd0);
        check("mid_firstbad", first_bad1, 8'h00);
        nf = 0;
        for (int cyc = 0; cyc < 300; cyc++) begin
            if (finish1) nf++;
            tick();
        end
        check("mid_no_finish", nf, 0);

        // Start held continuously
        fill_identity();
        sweep(1'b0, 519, -1, -1, 780, f1, f2, nf, sb, ab, pf);
        check("hold_fin1", f1, 258);
        check("hold_fin2", f2, 517);
        check("hold_period", f2 - f1, 259);
        check("hold_fin_count", nf, 3);
        check("hold_pass", pass1, 1'b1);

        // Start pulses while busy are ignored
        sweep(1'b0, 1, 50, 258, 600, f1, f2, nf, sb, ab, pf);
        check("busy_start_fin", f1, 258);
        check("busy_start_count", nf, 1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
